// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared types and constants for the UART transmit/receive blocks.
//           Holds the transmitter state encoding, the parity selector
//           encodings, the default minimum baud divisor and a helper that
//           turns a clock frequency and baud rate into a divisor.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Divisors below this cannot be honoured, so they are raised to it.
  localparam int unsigned c_min_div_dflt = 4;

  // Clocks per bit for a given system clock and baud rate.
  function automatic int unsigned bps_div(input int unsigned clk_fre,
                                          input int unsigned bps);
    return (bps == 0) ? 0 : clk_fre / bps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync_fifo
// Purpose : Single-clock FIFO with first-word-fall-through read data.
//           Pointers carry an extra wrap bit so full and empty are
//           distinguishable and level can reach DEPTH.
// Ports   : sys_clk/sys_rst_n - clock, async active-low reset (empties FIFO)
//           push/wr_data      - write strobe and data (ignored when full)
//           pop/rd_data       - read strobe (ignored when empty), head word
//           full/empty/level  - occupancy flags and count 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign level   = r_wr_ptr - r_rd_ptr;
  assign rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_frame
// Purpose : UART transmitter with a TX FIFO and per-frame configuration.
//           Words are serialised LSB first as start, data, optional parity
//           and one or two stop bits. Queued frames follow back to back.
// Ports   : sys_clk/sys_rst_n        - clock, async active-low reset
//           tx_data/tx_valid/tx_ready - word input handshake
//           cfg_div                   - clocks per bit (clamped to MIN_DIV)
//           cfg_parity                - 00 none, 01 odd, 10 even, 11 none
//           cfg_stop2                 - 1 = two stop bits
//           uart_txd                  - serial line, idle high, registered
//           tx_busy                   - frame in progress
//           tx_done                   - pulse in last clock of last stop bit
//           fifo_level                - FIFO occupancy
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_DIV    = c_min_div_dflt
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [3:0]       c_last_data = 4'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] c_min_div   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] c_one       = DIV_W'(1);

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic [DIV_W-1:0]     r_div;
  logic [DIV_W-1:0]     r_cnt;
  logic [DIV_W-1:0]     w_div_sel;
  logic [3:0]           r_bit;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_stop2;
  logic                 r_txd;
  logic                 r_done;
  logic                 r_busy;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_txd_nxt;
  logic                 w_done_nxt;
  logic                 w_cfg_par_en;
  logic                 w_cfg_par_bit;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (w_push),
    .wr_data   (tx_data),
    .pop       (w_pop),
    .rd_data   (w_fifo_dout),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  assign w_push   = tx_valid && !w_full;
  assign tx_ready = !w_full;

  // Frame configuration is sampled from these only at the pop.
  assign w_div_sel     = (cfg_div < c_min_div) ? c_min_div : cfg_div;
  assign w_cfg_par_en  = (cfg_parity == PAR_ODD) || (cfg_parity == PAR_EVEN);
  assign w_cfg_par_bit = (cfg_parity == PAR_ODD) ? ~^w_fifo_dout : ^w_fifo_dout;

  assign w_bit_end   = (r_cnt == r_div - c_one);
  assign w_last_stop = (r_bit == {3'b000, r_stop2});

  // Next state and the line level for the following clock. The line is
  // registered, so it trails the state register by one clock.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done_nxt  = 1'b0;
    w_txd_nxt   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_txd_nxt = r_shift[0];
        if (w_bit_end && (r_bit == c_last_data)) begin
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        w_txd_nxt = r_par_bit;
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end && w_last_stop) begin
          w_done_nxt = 1'b1;
          // Popping here puts the next start bit right after this stop bit.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_div     <= c_min_div;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_txd     <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_txd   <= w_txd_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (r_state != ST_IDLE);
      if (w_pop) begin
        r_shift   <= w_fifo_dout;
        r_div     <= w_div_sel;
        r_par_en  <= w_cfg_par_en;
        r_par_bit <= w_cfg_par_bit;
        r_stop2   <= cfg_stop2;
        r_cnt     <= '0;
        r_bit     <= '0;
      end else if (r_state != ST_IDLE) begin
        if (w_bit_end) begin
          r_cnt <= '0;
          // Bit index counts data bits in DATA and stop bits in STOP.
          r_bit <= (w_state_nxt == r_state) ? r_bit + 4'd1 : 4'd0;
          if (r_state == ST_DATA) begin
            r_shift <= r_shift >> 1;
          end
        end else begin
          r_cnt <= r_cnt + c_one;
        end
      end
    end
  end

  assign uart_txd = r_txd;
  assign tx_done  = r_done;
  assign tx_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_frame
// Purpose : Self-checking bench for uart_tx_frame. Expected line waveforms
//           are built from frame rules (start, data LSB first, parity, stop
//           bits, each a clamped divisor long) and compared per clock.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

  localparam int DATA_BITS  = 8;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LOGN       = 16384;

  logic        sys_clk    = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic [7:0]  tx_data    = '0;
  logic        tx_valid   = 1'b0;
  logic        tx_ready;
  logic [15:0] cfg_div    = 16'd4;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2  = 1'b0;
  logic        uart_txd;
  logic        tx_busy;
  logic        tx_done;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic log_txd  [LOGN];
  logic log_done [LOGN];
  logic log_busy [LOGN];
  bit   exp_txd  [$];
  bit   exp_done [$];

  uart_tx_frame #(
    .DATA_BITS  (DATA_BITS),
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MIN_DIV    (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Value of each output during the clock that began at edge number cyc.
  always @(negedge sys_clk) begin
    if (cyc < LOGN) begin
      log_txd[cyc]  = uart_txd;
      log_done[cyc] = tx_done;
      log_busy[cyc] = tx_busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Append the expected line levels of one frame, one entry per clock.
  task automatic model_frame(input logic [7:0] d, input int unsigned div,
                             input logic [1:0] par, input bit stop2);
    bit          lv[$];
    int unsigned eff;
    int unsigned ones;
    eff  = (div < 4) ? 4 : div;
    ones = $countones(d);
    lv.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) lv.push_back(d[i]);
    if (par == 2'b01) lv.push_back((ones % 2) == 0);
    if (par == 2'b10) lv.push_back((ones % 2) == 1);
    lv.push_back(1'b1);
    if (stop2) lv.push_back(1'b1);
    foreach (lv[k]) begin
      for (int unsigned c = 0; c < eff; c++) begin
        exp_txd.push_back(lv[k]);
        exp_done.push_back((k == lv.size() - 1) && (c == eff - 1));
      end
    end
  endtask

  // Compare the logged line from cycle 'start' against the model queue.
  task automatic check_stream(input int start, input int tail, input string tag);
    int n;
    int b0;
    for (int i = 0; i < tail; i++) begin
      exp_txd.push_back(1'b1);
      exp_done.push_back(1'b0);
    end
    n = exp_txd.size();
    while (cyc < start + n) step();
    @(negedge sys_clk);
    #1;
    chk({tag, "_pre_idle"}, 32'(log_txd[start-1]), 32'd1);
    chk({tag, "_busy_mid"}, 32'(log_busy[start+2]), 32'd1);
    chk({tag, "_busy_after"}, 32'(log_busy[start+n-1]), 32'd0);
    b0 = bad;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_txd@%0d", tag, i), 32'(log_txd[start+i]), 32'(exp_txd[i]));
      chk($sformatf("%s_done@%0d", tag, i), 32'(log_done[start+i]), 32'(exp_done[i]));
      if (bad != b0) break;
    end
    exp_txd.delete();
    exp_done.delete();
  endtask

  // Offer a word and return the edge number at which it was taken.
  task automatic push_word(input logic [7:0] d, output int pc);
    int waited;
    waited   = 0;
    pc       = -1;
    tx_data  = d;
    tx_valid = 1'b1;
    while (pc < 0 && waited < 2000) begin
      if (tx_ready === 1'b1) begin
        step();
        pc = cyc;
      end else begin
        step();
        waited++;
      end
    end
    tx_valid = 1'b0;
    chk("push_accepted", {31'b0, pc >= 0}, 32'd1);
  endtask

  initial begin
    int p;
    int p0;
    int pcs[6];
    int lv_exp[5];
    int c0;
    logic [7:0]  rd;
    int unsigned rdiv;
    logic [1:0]  rpar;
    bit          rstop;

    // Reset and idle
    repeat (3) step();
    sys_rst_n = 1'b1;
    c0 = cyc;
    repeat (20) step();
    @(negedge sys_clk);
    #1;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    for (int i = c0 + 1; i <= c0 + 20; i++) begin
      chk("idle_txd", 32'(log_txd[i]), 32'd1);
      chk("idle_done", 32'(log_done[i]), 32'd0);
    end
    step();

    // 8N1 div 4, 0x55
    cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    push_word(8'h55, p);
    model_frame(8'h55, 4, 2'b00, 1'b0);
    check_stream(p + 2, 4, "8n1_55");

    // Parity and two stop bits
    cfg_parity = 2'b10;
    push_word(8'h07, p);
    model_frame(8'h07, 4, 2'b10, 1'b0);
    check_stream(p + 2, 4, "even_07");
    cfg_parity = 2'b01;
    push_word(8'h07, p);
    model_frame(8'h07, 4, 2'b01, 1'b0);
    check_stream(p + 2, 4, "odd_07");
    cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    push_word(8'h07, p);
    model_frame(8'h07, 4, 2'b10, 1'b1);
    check_stream(p + 2, 4, "even_stop2_07");
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;

    // FIFO fill with valid held, back-to-back frames
    lv_exp = '{1, 1, 2, 3, 4};
    for (int i = 0; i < 5; i++) begin
      push_word(8'hA0 + 8'(i), pcs[i]);
      chk($sformatf("fifo_level_%0d", i), 32'(fifo_level), 32'(lv_exp[i]));
    end
    p0 = pcs[0];
    for (int i = 1; i < 5; i++) chk($sformatf("fifo_accept_cyc_%0d", i), pcs[i], p0 + i);
    chk("fifo_full_ready", 32'(tx_ready), 32'd0);
    push_word(8'hA5, pcs[5]);
    chk("fifo_sixth_accept", pcs[5], p0 + 42);
    for (int i = 0; i < 6; i++) model_frame(8'hA0 + 8'(i), 4, 2'b00, 1'b0);
    check_stream(p0 + 2, 4, "fifo_burst");
    chk("fifo_drained", 32'(fifo_level), 32'd0);

    // Divisor clamp
    cfg_div = 16'd1;
    push_word(8'hC3, p);
    model_frame(8'hC3, 1, 2'b00, 1'b0);
    check_stream(p + 2, 4, "clamp_div1");

    // Divisor change mid-frame applies to the next frame only
    cfg_div = 16'd4;
    push_word(8'h96, p);
    push_word(8'h69, p0);
    chk("divchg_second_push", p0, p + 1);
    while (cyc < p + 10) step();
    cfg_div = 16'd8;
    model_frame(8'h96, 4, 2'b00, 1'b0);
    model_frame(8'h69, 8, 2'b00, 1'b0);
    check_stream(p + 2, 4, "div_change");

    // Randomised single frames
    for (int it = 0; it < 10; it++) begin
      rd    = 8'($urandom);
      rdiv  = $urandom_range(1, 9);
      rpar  = 2'($urandom_range(0, 3));
      rstop = 1'($urandom_range(0, 1));
      cfg_div = 16'(rdiv); cfg_parity = rpar; cfg_stop2 = rstop;
      push_word(rd, p);
      model_frame(rd, rdiv, rpar, rstop);
      check_stream(p + 2, 4, $sformatf("rand%0d", it));
    end

    // Reset during data bit 3 with words still queued
    cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    push_word(8'hA5, p);
    push_word(8'h11, p0);
    push_word(8'h22, p0);
    while (cyc < p + 19) step();
    chk("rst_mid_before", 32'(uart_txd), 32'd0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", 32'(uart_txd), 32'd1);
    chk("rst_mid_level", 32'(fifo_level), 32'd0);
    chk("rst_mid_busy", 32'(tx_busy), 32'd0);
    chk("rst_mid_ready", 32'(tx_ready), 32'd1);
    repeat (3) step();
    sys_rst_n = 1'b1;
    repeat (2) step();
    push_word(8'h3C, p);
    model_frame(8'h3C, 4, 2'b00, 1'b0);
    check_stream(p + 2, 20, "after_rst_3c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
